// File: rtl/midi_pkg.sv
// Shared types and helpers for the MIDI transmit path.
package midi_pkg;

  localparam int MIDI_BAUD = 31250;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  function automatic int bit_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/midi_uart_tx_sync_fifo.sv
// Show-ahead synchronous FIFO; DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI_OUT 8N1 serialiser fed by a byte buffer. Define MIDI_TX_FIFO_EN for a
// FIFO_DEPTH-entry FIFO; otherwise a single holding register buffers one byte.
module midi_uart_tx
  import midi_pkg::*;
#(
  parameter int CLK_HZ     = 32000000,
  parameter int BAUD       = MIDI_BAUD,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk32,
  input  logic                        reset,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_wr,
  output logic                        tx_full,
  output logic                        tx_empty,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic                        tx_ovf,
  output logic                        midi_out
);

  localparam int BIT_DIV = bit_div(CLK_HZ, BAUD);
  localparam int CW      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int LW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_DIV - 1);

  logic          buf_full;
  logic          buf_empty;
  logic [7:0]    buf_rdata;
  logic [LW-1:0] buf_level;
  logic          push;
  logic          pop;

  // Full comes from registered state, so a write coinciding with a pop while full is dropped.
  assign push = tx_wr & ~buf_full;

`ifdef MIDI_TX_FIFO_EN
  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk32),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .wdata (tx_data),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_level)
  );
`else
  logic       hold_valid;
  logic [7:0] hold_data;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= tx_data;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign buf_full  = hold_valid;
  assign buf_empty = ~hold_valid;
  assign buf_rdata = hold_data;
  assign buf_level = LW'(hold_valid);
`endif

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          out_q, out_d;
  logic          ovf_q;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      out_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      ovf_q   <= tx_wr & buf_full;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    out_d   = out_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!buf_empty) begin
          pop     = 1'b1;
          shift_d = buf_rdata;
          out_d   = 1'b0;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          out_d   = shift_q[0];
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            out_d   = 1'b1;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            out_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Pop straight into the next start bit so consecutive frames have no idle gap.
          if (!buf_empty) begin
            pop     = 1'b1;
            shift_d = buf_rdata;
            out_d   = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign midi_out = out_q;
  assign tx_full  = buf_full;
  assign tx_empty = buf_empty && (state_q == IDLE);
  assign tx_level = buf_level;
  assign tx_ovf   = ovf_q;

endmodule

// File: tb/tb_midi_uart_tx.sv
// Directed bench for midi_uart_tx at a reduced bit period (16 clocks) to keep runs short.
module tb_midi_uart_tx;

  localparam int BD    = 16;
  localparam int CLKHZ = 31250 * BD;
  localparam int FD    = 16;
  localparam int FL    = 10 * BD;
  localparam int NCAP  = 3000;

  logic       clk32 = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic       tx_empty;
  logic [4:0] tx_level;
  logic       tx_ovf;
  logic       midi_out;

  midi_uart_tx #(.CLK_HZ(CLKHZ), .BAUD(31250), .FIFO_DEPTH(FD)) dut (
    .clk32    (clk32),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .tx_level (tx_level),
    .tx_ovf   (tx_ovf),
    .midi_out (midi_out)
  );

  always #5 clk32 = ~clk32;

  int checks = 0;
  int errors = 0;

  logic       sched_wr [NCAP];
  logic [7:0] sched_d  [NCAP];
  logic       cap      [NCAP];
  logic       full_c   [NCAP];
  logic       ovf_c    [NCAP];
  logic       emp_c    [NCAP];
  logic [4:0] lvl_c    [NCAP];
  logic [7:0] ovb      [18];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic clr_sched();
    for (int i = 0; i < NCAP; i++) begin
      sched_wr[i] = 1'b0;
      sched_d[i]  = 8'h00;
    end
  endtask

  task automatic start_frame(input logic [7:0] b);
    tx_wr   = 1'b1;
    tx_data = b;
    tick();
    tx_wr   = 1'b0;
  endtask

  // Sample i is taken just after the edge where scheduled write i (if any) is presented.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tx_wr   = sched_wr[i];
      tx_data = sched_d[i];
      tick();
      tx_wr     = 1'b0;
      cap[i]    = midi_out;
      full_c[i] = tx_full;
      ovf_c[i]  = tx_ovf;
      emp_c[i]  = tx_empty;
      lvl_c[i]  = tx_level;
    end
  endtask

  function automatic logic frame_match(input int off, input logic [7:0] b);
    logic e;
    for (int p = 0; p < 10; p++) begin
      for (int c = 0; c < BD; c++) begin
        e = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[p-1];
        if (cap[off + p*BD + c] !== e) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic all_high(input int n);
    for (int i = 0; i < n; i++) if (cap[i] !== 1'b1) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    tx_wr   = 1'b0;
    tx_data = 8'h00;
    clr_sched();
    tick();
    tick();
    chk("rst_midi_out", midi_out, 1);
    chk("rst_full",     tx_full,  0);
    chk("rst_empty",    tx_empty, 1);
    chk("rst_level",    tx_level, 0);
    chk("rst_ovf",      tx_ovf,   0);
    reset = 1'b0;
    repeat (8) tick();

    // Single byte 0x90
    start_frame(8'h90);
    chk("single_level_after_wr", tx_level, 1);
    chk("single_line_before_start", midi_out, 1);
    chk("single_empty_after_wr", tx_empty, 0);
    run(FL + 1);
    chk("single_start_latency", cap[0], 0);
    chk("single_frame_0x90", frame_match(0, 8'h90), 1);
    chk("single_empty_in_stop", emp_c[FL-1], 0);
    chk("single_empty_at_end", emp_c[FL], 1);
    chk("single_idle_line", cap[FL], 1);
    repeat (5) tick();

    // Back-to-back 0x90 0x3C 0x7F
    clr_sched();
`ifdef MIDI_TX_FIFO_EN
    sched_wr[0] = 1'b1; sched_d[0] = 8'h3C;
    sched_wr[1] = 1'b1; sched_d[1] = 8'h7F;
`else
    sched_wr[1]  = 1'b1; sched_d[1]  = 8'h3C;
    sched_wr[FL+1] = 1'b1; sched_d[FL+1] = 8'h7F;
`endif
    start_frame(8'h90);
    run(3*FL + 1);
`ifdef MIDI_TX_FIFO_EN
    chk("b2b_level", lvl_c[1], 2);
`else
    chk("b2b_hold_full", full_c[1], 1);
`endif
    chk("b2b_frame0", frame_match(0,    8'h90), 1);
    chk("b2b_frame1", frame_match(FL,   8'h3C), 1);
    chk("b2b_frame2", frame_match(2*FL, 8'h7F), 1);
    chk("b2b_idle_line", cap[3*FL], 1);
    chk("b2b_empty_end", emp_c[3*FL], 1);
    repeat (5) tick();

`ifdef MIDI_TX_FIFO_EN
    // Overflow: 18 writes on consecutive cycles while idle
    clr_sched();
    for (int j = 0; j < 18; j++) ovb[j] = 8'(j*37 + 5);
    for (int j = 1; j < 18; j++) begin
      sched_wr[j-1] = 1'b1;
      sched_d[j-1]  = ovb[j];
    end
    start_frame(ovb[0]);
    run(17*FL + 1);
    chk("ovf_level_full", lvl_c[15], 16);
    chk("ovf_full_flag",  full_c[15], 1);
    chk("ovf_no_pulse_early", ovf_c[15], 0);
    chk("ovf_pulse", ovf_c[16], 1);
    chk("ovf_level_hold", lvl_c[16], 16);
    chk("ovf_pulse_width", ovf_c[17], 0);
    for (int j = 0; j < 17; j++)
      chk($sformatf("ovf_frame%0d", j), frame_match(j*FL, ovb[j]), 1);
    chk("ovf_idle_after17", cap[17*FL], 1);
    chk("ovf_empty_end", emp_c[17*FL], 1);
    repeat (5) tick();

    // Push and pop on the STOP-end edge with four bytes queued
    clr_sched();
    sched_wr[0] = 1'b1; sched_d[0] = 8'hF1;
    sched_wr[1] = 1'b1; sched_d[1] = 8'hF2;
    sched_wr[2] = 1'b1; sched_d[2] = 8'hF3;
    sched_wr[3] = 1'b1; sched_d[3] = 8'hF4;
    sched_wr[FL] = 1'b1; sched_d[FL] = 8'hF5;
    start_frame(8'hF0);
    run(6*FL + 1);
    chk("pp_level_before", lvl_c[FL-1], 4);
    chk("pp_level_after",  lvl_c[FL],   4);
    for (int j = 0; j < 6; j++)
      chk($sformatf("pp_frame%0d", j), frame_match(j*FL, 8'(8'hF0 + j)), 1);
    chk("pp_idle_line", cap[6*FL], 1);
    repeat (5) tick();
`else
    // Holding register: second write fills it, third write is dropped
    clr_sched();
    sched_wr[1] = 1'b1; sched_d[1] = 8'h02;
    sched_wr[5] = 1'b1; sched_d[5] = 8'h03;
    start_frame(8'h01);
    run(2*FL + 10);
    chk("hold_full_set",    full_c[1], 1);
    chk("hold_level",       lvl_c[1], 1);
    chk("hold_no_ovf",      ovf_c[4], 0);
    chk("hold_ovf_pulse",   ovf_c[5], 1);
    chk("hold_ovf_width",   ovf_c[6], 0);
    chk("hold_full_late",   full_c[FL-1], 1);
    chk("hold_full_clear",  full_c[FL], 0);
    chk("hold_frame_01",    frame_match(0,  8'h01), 1);
    chk("hold_frame_02",    frame_match(FL, 8'h02), 1);
    chk("hold_no_third",    cap[2*FL + 5], 1);
    chk("hold_empty_end",   emp_c[2*FL + 5], 1);
    repeat (5) tick();
`endif

    // Reset during data bit 3 of 0x55 with more bytes buffered
    clr_sched();
`ifdef MIDI_TX_FIFO_EN
    sched_wr[0] = 1'b1; sched_d[0] = 8'hAA;
    sched_wr[1] = 1'b1; sched_d[1] = 8'h0F;
`else
    sched_wr[1] = 1'b1; sched_d[1] = 8'hAA;
`endif
    start_frame(8'h55);
    run(4*BD + BD/2 + 1);
    chk("mid_line_bit3", midi_out, 0);
`ifdef MIDI_TX_FIFO_EN
    chk("mid_level", tx_level, 2);
`else
    chk("mid_level", tx_level, 1);
`endif
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_line",  midi_out, 1);
    chk("mid_rst_level", tx_level, 0);
    chk("mid_rst_empty", tx_empty, 1);
    chk("mid_rst_full",  tx_full,  0);
    tick();
    tick();
    reset = 1'b0;
    clr_sched();
    run(2*FL);
    chk("post_rst_quiet", all_high(2*FL), 1);
    chk("post_rst_empty", emp_c[2*FL-1], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_uart_tx.md
Name: midi_uart_tx

Overview:
- Serial transmitter that drives the MIDI_OUT pin. It is the transmit half of the C64 MIDI-cartridge ACIA emulation; the existing MIDI_IN path is the receive half.
- The CPU-side register logic pushes bytes into a small FIFO.
- The block serialises each byte as 8N1 asynchronous frames at the MIDI rate (31250 baud), LSB first.
- The line idles high.

Parameters:
- CLK_HZ, 32000000, frequency of clk32 in Hz.
- BAUD, 31250, bit rate. BIT_DIV = CLK_HZ/BAUD, which is 1024 at defaults; integer division, truncated.
- FIFO_DEPTH, 16, number of FIFO entries; must be a power of two, at least 2.

Ports:
- clk32  in  1  core clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to transmit.
- tx_wr  in  1  one-cycle write strobe; tx_data is captured on this edge.
- tx_full  out  1  high when no further write can be accepted.
- tx_empty  out  1  high when the FIFO is empty and the shifter is idle (transmitter fully drained).
- tx_level  out  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO, excluding the byte in the shifter.
- tx_ovf  out  1  one-cycle pulse when a write is dropped because tx_full was high.
- midi_out  out  1  serial line, registered output.

Behaviour:
- Reset values, applied immediately because reset is asynchronous:
  - midi_out=1, tx_full=0, tx_empty=1, tx_level=0, tx_ovf=0.
  - FIFO pointers cleared, state IDLE, baud counter 0.
- Reset mid-frame aborts the frame and returns the line high at once. Bytes already in the FIFO are discarded.
- Write rules:
  - tx_wr with tx_full=0: the byte is stored and tx_level increments after that edge.
  - tx_wr with tx_full=1: the byte is dropped and tx_ovf pulses on the next cycle.
  - tx_full is evaluated from registered state. A write in the same cycle as a pop while full is still dropped.
- State machine IDLE -> START -> DATA -> STOP -> (START | IDLE):
  - IDLE: if the FIFO is non-empty, pop into the 8-bit shifter, set midi_out=0, clear the baud counter, go to START. Latency: tx_wr at edge k into an empty block gives midi_out=0 after edge k+1.
  - START: hold for BIT_DIV cycles. Then output bit0, set bit index to 0, go to DATA.
  - DATA: each bit is held BIT_DIV cycles. After bit index 7, set midi_out=1 and go to STOP.
  - STOP: hold BIT_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START with midi_out=0, so there is no idle gap between frames. Otherwise go to IDLE.
- A frame is exactly 10*BIT_DIV cycles.
- Baud counter: counts 0..BIT_DIV-1, reloaded at each bit boundary. Width is $clog2(BIT_DIV).
- Simultaneous write into an empty FIFO and pop: cannot occur, because a pop only happens when the FIFO is non-empty.
- Simultaneous write and pop with a non-empty FIFO: tx_level is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. The count distinguishes full from empty.

Optional Feature:
- Macro: MIDI_TX_FIFO_EN.
- Defined: FIFO of FIFO_DEPTH entries as described above.
- Undefined:
  - The FIFO is replaced by a single holding register, and FIFO_DEPTH is ignored.
  - tx_level is 0 or 1.
  - tx_full = holding register occupied.
  - Capacity is 1 byte plus the byte in the shifter. Back-to-back frames are still gapless when the holding register is refilled before STOP ends.

Decomposition:
- Package midi_pkg holds:
  - the state enum tx_state_t {IDLE, START, DATA, STOP};
  - the function bit_div(CLK_HZ, BAUD);
  - the localparam MIDI_BAUD = 31250.
- One sub-module, sync_fifo: width 8, depth FIFO_DEPTH, with push, pop, full, empty and count signals. It is instantiated only under MIDI_TX_FIFO_EN.

Test Plan:
- Single byte: reset, write 0x90 at cycle 10.
  - midi_out goes low at cycle 11.
  - Then bits 0,0,0,0,1,0,0,1 follow, each 1024 cycles, LSB first.
  - Stop bit high; tx_empty=1 at cycle 11+10240.
- Back-to-back: write 0x90, 0x3C, 0x7F on consecutive cycles.
  - Three frames are contiguous (30720 cycles) with no high gap beyond the stop bits.
  - The sampled bytes match.
- Overflow (FIFO_EN): write 18 bytes while idle.
  - The first is popped into the shifter; 16 are held, so tx_level=16 and tx_full=1.
  - The 18th write is dropped with a one-cycle tx_ovf pulse.
  - 17 frames are transmitted.
- Reset mid-frame: assert reset during data bit 3 of 0x55.
  - midi_out=1 in the same cycle, before the next edge.
  - tx_level=0, tx_empty=1; no further frames after reset is released.
- Simultaneous push/pop: keep tx_level=4, issue tx_wr on the exact STOP-end pop cycle.
  - tx_level stays 4; byte ordering is preserved.
- Non-FIFO build (macro undefined): write 0x01 then 0x02.
  - The second write raises tx_full until the first frame ends.
  - A third write during that time pulses tx_ovf.
